// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: sequential W-bit adder that walks one 4-bit carry-lookahead
// stage over the operand nibbles, LSB nibble first, one nibble per cycle.
// Optional feature: define CLA_SEQ_OVF_EN to register signed overflow on ovf;
// with the macro undefined, ovf is tied low.

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p, c;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end
endmodule

module cla_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic [3:0]    stg_a, stg_b, stg_sum;
  logic          stg_cout;

  // Nibble [cnt] of each latched operand feeds the single lookahead stage
  assign stg_a = a_q[{cnt_q, 2'b00} +: 4];
  assign stg_b = b_q[{cnt_q, 2'b00} +: 4];

  cla u_cla (
    .a    (stg_a),
    .b    (stg_b),
    .cin  (carry_q),
    .sum  (stg_sum),
    .cout (stg_cout)
  );

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Next-state and datapath updates; everything holds unless the FSM says otherwise
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = cin;
        end
      end
      RUN: begin
        work_d[{cnt_q, 2'b00} +: 4] = stg_sum;
        carry_d = stg_cout;
        if (cnt_q == LAST) begin
          // Last nibble: publish the working register including this cycle's nibble.
          // The counter stops here rather than wrapping.
          state_d = DONE;
          sum_d   = work_d;
          cout_d  = stg_cout;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf   = ovf_q;
`else
  assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl (NIBBLES=4) with an expected-result queue.
module tb_cla_seq_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cla_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
    e.s  = full[W-1:0];
    e.c  = full[W];
`ifdef CLA_SEQ_OVF_EN
    e.o  = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
`else
    e.o  = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"},  32'(sum),  32'(e.s));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      chk({tag, "_ovf"},  32'(ovf),  32'(e.o));
    end
  endtask

  // One start pulse; optionally re-pulse start with new operands in cycle 2
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                        input string tag, input bit disturb);
    int cyc, got, extra;
    a = aa; b = bb; cin = cc; start = 1'b1;
    push(aa, bb, cc);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 0;
    while (cyc <= 20) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, 32'(got), 32'(N + 1));
    if (got != 0) pop_cmp(tag);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) extra++;
      @(negedge clk);
    end
    chk({tag, "_extra_done"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int cyc, d1, d2, extra;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(cout),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, "carry_nib", 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, "full_ripple", 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, "ignore_start", 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, "signed_ovf", 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, "neg_ovf", 1'b0);

    // Start held high: two back-to-back operations
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; start = 1'b1;
    push(a, b, cin);
    push(a, b, cin);
    @(posedge clk);
    @(negedge clk);
    cyc = 1; d1 = 0; d2 = 0;
    while (cyc <= 30 && d2 == 0) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
        end
        pop_cmp("b2b");
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'(N + 1));
    chk("b2b_period", 32'(d2 - d1), 32'(N + 2));
    repeat (3) @(negedge clk);
    chk("b2b_idle", 32'(ready), 32'd1);

    // Reset in the middle of RUN aborts with no done pulse
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_done", 32'(done),  32'd0);
    chk("abort_sum",  32'(sum),   32'd0);
    chk("abort_cout", 32'(cout),  32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) extra++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    run_op(16'h0001, 16'h0002, 1'b0, "after_abort", 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (legal range 2..16); W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an addition; accepted only when ready=1.
REQ-005 SHALL have port a, input, W, operand A; sampled on the accepted start.
REQ-006 SHALL have port b, input, W, operand B; sampled on the accepted start.
REQ-007 SHALL have port cin, input, 1, carry-in; sampled on the accepted start.
REQ-008 SHALL have port ready, output, 1, high when in IDLE.
REQ-009 SHALL have port busy, output, 1, high when in RUN.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 SHALL have port sum, output, W, the registered result.
REQ-012 SHALL have port cout, output, 1, the registered carry-out.
REQ-013 SHALL have port ovf, output, 1, registered signed overflow (see Configuration).

Function
REQ-014 SHALL perform the W-bit addition a+b+cin by sequencing one 4-bit carry-lookahead stage (one cla instance: a, b, cin, sum, cout) over the nibbles, LSB nibble first, one nibble per cycle.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the nibble with index NIBBLES-1.
  - DONE -> IDLE unconditionally after one cycle.
REQ-016 On an accepted start, SHALL latch a, b and cin into operand registers, set the nibble counter to 0 and load the carry register with cin.
REQ-017 In RUN, each cycle SHALL do the following:
  - feed nibble[cnt] of A and B plus the carry register to the stage;
  - write the stage sum into nibble[cnt] of the working register;
  - load the stage cout into the carry register;
  - increment cnt.
REQ-018 On the RUN -> DONE transition, SHALL copy the working register into sum and the final carry into cout; sum, cout and ovf SHALL then hold until the next completion.
REQ-019 done SHALL be high exactly in the DONE cycle, i.e. NIBBLES+1 cycles after the edge that accepted start.
REQ-020 start SHALL be ignored in RUN and DONE; operand changes during RUN SHALL NOT affect the result.
REQ-021 start held high continuously SHALL yield back-to-back operations with a throughput of one result per NIBBLES+2 cycles.
REQ-022 The counter SHALL be ceil(log2(NIBBLES)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL apply the following reset values:
  - state = IDLE;
  - ready = 1;
  - busy = 0;
  - done = 0;
  - sum = 0;
  - cout = 0;
  - ovf = 0;
  - counter, carry and working registers = 0.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n returns high SHALL be accepted.

Configuration
REQ-025 Macro CLA_SEQ_OVF_EN SHALL control signed overflow reporting.
  - Defined: ovf is registered at completion as (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using the latched operands.
  - Undefined: the ovf port remains present, tied to 0, and no overflow logic is generated.

Verification (NIBBLES=4)
REQ-026 a=16'h00FF, b=16'h0001, cin=0, start pulse -> sum=16'h0100, cout=0, done exactly 5 cycles after the start edge.
REQ-027 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (full carry ripple across all nibbles).
REQ-028 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; start pulsed again in cycle 2 with other operands -> ignored, single done pulse.
REQ-029 a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, with ovf=1 if CLA_SEQ_OVF_EN is defined and ovf=0 otherwise.
REQ-030 Start a=16'hFFFF, b=16'hFFFF, then rst_n=0 in cycle 2 -> no done pulse, sum=0, cout=0, ready=1; next start with a=16'h0001, b=16'h0002 -> sum=16'h0003.
